// File: rtl/gray_seq_ctrl.sv
// Command-driven sequencer for a Gray counter. It accepts STOP / STEP / BURST / RUN
// commands on a valid-ready port, drives the counter enable, and watches the counter's
// Gray output for wrap-around and illegal multi-bit transitions.
module gray_seq_ctrl #(
  parameter int unsigned SIZE  = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [LEN_W-1:0]          cmd_len_i,
  input  logic                      hold_i,
  input  logic [$clog2(SIZE)-1:0]   cnt_gray_i,
  output logic                      cnt_en_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      cmd_err_o,
  output logic                      wrap_o,
  output logic                      gray_err_o
);

  localparam int unsigned W = $clog2(SIZE);

  localparam logic [1:0] OpStop  = 2'b00;
  localparam logic [1:0] OpStep  = 2'b01;
  localparam logic [1:0] OpBurst = 2'b10;
  localparam logic [1:0] OpRun   = 2'b11;

  localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);
  localparam logic [W-1:0]     GrayOne = W'(1);

  typedef enum logic [1:0] {
    StIdle,
    StStep,
    StBurst,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              cnt_en_q, cnt_en_d;
  logic              done_q, done_d;
  logic              cmd_err_q, cmd_err_d;
  logic              wrap_q, wrap_d;
  logic              gray_err_q, gray_err_d;
  logic [W-1:0]      gray_prev_q;

  logic              cmd_acc;
  logic [W-1:0]      gray_diff;
  logic              gray_changed;
  logic              gray_one_bit;
  logic              gray_to_zero;

  // State register and all registered outputs, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cnt_en_q    <= 1'b0;
      done_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      wrap_q      <= 1'b0;
      gray_err_q  <= 1'b0;
      gray_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cnt_en_q    <= cnt_en_d;
      done_q      <= done_d;
      cmd_err_q   <= cmd_err_d;
      wrap_q      <= wrap_d;
      gray_err_q  <= gray_err_d;
      gray_prev_q <= cnt_gray_i;
    end
  end

  // Next-state: command decode, step/burst bookkeeping and completion pulses.
  // An enable cycle is "consumed" when cnt_en_q was high during the current cycle,
  // so cycles suppressed by hold never count against a STEP or BURST.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    cmd_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_acc) begin
          unique case (cmd_op_i)
            OpStop: begin
              state_d = StIdle;
            end
            OpStep: begin
              state_d = StStep;
            end
            OpBurst: begin
              if (cmd_len_i != '0) begin
                state_d     = StBurst;
                remaining_d = cmd_len_i;
              end else begin
                // Zero-length burst completes immediately without enabling.
                done_d = 1'b1;
              end
            end
            OpRun: begin
              state_d = StRun;
            end
            default: begin
              state_d = StIdle;
            end
          endcase
        end
      end
      StStep: begin
        if (cnt_en_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StBurst: begin
        if (cnt_en_q) begin
          remaining_d = remaining_q - LenOne;
          if (remaining_q == LenOne) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRun: begin
        if (cmd_acc) begin
          if (cmd_op_i == OpStop) begin
            state_d = StIdle;
          end else begin
            // Anything but STOP is dropped while free-running.
            cmd_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: handshake/status decode and the next value of the registered enable.
  always_comb begin
    cmd_ready_o = (state_q == StIdle) || (state_q == StRun);
    busy_o      = (state_q != StIdle);
    cmd_acc     = cmd_valid_i && cmd_ready_o;
    // Enable follows the state we are about to enter, gated by this cycle's hold.
    cnt_en_d    = (state_d != StIdle) && !hold_i;
    cnt_en_o    = cnt_en_q;
    done_o      = done_q;
    cmd_err_o   = cmd_err_q;
    wrap_o      = wrap_q;
    gray_err_o  = gray_err_q;
  end

  // Monitor: compares the counter output with last cycle's value, independent of state.
  // A change to zero is a wrap and may flip several bits when SIZE is not a power of 2.
  always_comb begin
    gray_diff    = cnt_gray_i ^ gray_prev_q;
    gray_changed = (gray_diff != '0);
    gray_one_bit = gray_changed && ((gray_diff & (gray_diff - GrayOne)) == '0);
    gray_to_zero = gray_changed && (cnt_gray_i == '0);
    wrap_d       = gray_to_zero;
    gray_err_d   = gray_err_q || (gray_changed && !gray_to_zero && !gray_one_bit);
  end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed bench for gray_seq_ctrl: two instances (SIZE=16 and SIZE=10), each driving
// a small behavioural Gray counter, with hand-computed expectations.
module tb_gray_seq_ctrl;

  localparam logic [1:0] OpStop  = 2'b00;
  localparam logic [1:0] OpStep  = 2'b01;
  localparam logic [1:0] OpBurst = 2'b10;
  localparam logic [1:0] OpRun   = 2'b11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // SIZE=16 instance signals
  logic       v16, rdy16, hold16, en16, busy16, done16, err16, wrap16, gerr16;
  logic [1:0] op16;
  logic [7:0] len16;
  logic [3:0] gray16, bin16, fval16;
  logic       force16;

  // SIZE=10 instance signals
  logic       v10, rdy10, hold10, en10, busy10, done10, err10, wrap10, gerr10;
  logic [1:0] op10;
  logic [7:0] len10;
  logic [3:0] gray10, bin10;

  int n_checks = 0;
  int n_pass   = 0;

  gray_seq_ctrl #(.SIZE(16), .LEN_W(8)) dut16 (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid_i(v16),
    .cmd_ready_o(rdy16),
    .cmd_op_i   (op16),
    .cmd_len_i  (len16),
    .hold_i     (hold16),
    .cnt_gray_i (gray16),
    .cnt_en_o   (en16),
    .busy_o     (busy16),
    .done_o     (done16),
    .cmd_err_o  (err16),
    .wrap_o     (wrap16),
    .gray_err_o (gerr16)
  );

  gray_seq_ctrl #(.SIZE(10), .LEN_W(8)) dut10 (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid_i(v10),
    .cmd_ready_o(rdy10),
    .cmd_op_i   (op10),
    .cmd_len_i  (len10),
    .hold_i     (hold10),
    .cnt_gray_i (gray10),
    .cnt_en_o   (en10),
    .busy_o     (busy10),
    .done_o     (done10),
    .cmd_err_o  (err10),
    .wrap_o     (wrap10),
    .gray_err_o (gerr10)
  );

  // Behavioural counters: output lags enable by one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bin16 <= 4'd0;
    else if (en16) bin16 <= (bin16 == 4'd15) ? 4'd0 : bin16 + 4'd1;
  end
  assign gray16 = force16 ? fval16 : (bin16 ^ (bin16 >> 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bin10 <= 4'd0;
    else if (en10) bin10 <= (bin10 == 4'd9) ? 4'd0 : bin10 + 4'd1;
  end
  assign gray10 = bin10 ^ (bin10 >> 1);

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send16(input logic [1:0] op, input logic [7:0] len);
    v16 = 1'b1; op16 = op; len16 = len;
    tick();
    v16 = 1'b0;
  endtask

  task automatic send10(input logic [1:0] op, input logic [7:0] len);
    v10 = 1'b1; op10 = op; len10 = len;
    tick();
    v10 = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  int en_n, done_n, last_en, done_at, wraps, pre_wrap, h1, h2;

  initial begin
    v16 = 0; op16 = 0; len16 = 0; hold16 = 0; force16 = 0; fval16 = 0;
    v10 = 0; op10 = 0; len10 = 0; hold10 = 0;
    reset = 1'b1;
    repeat (3) tick();

    // Reset values
    check("rst_en",   int'(en16),   0);
    check("rst_busy", int'(busy16), 0);
    check("rst_done", int'(done16), 0);
    check("rst_cerr", int'(err16),  0);
    check("rst_wrap", int'(wrap16), 0);
    check("rst_gerr", int'(gerr16), 0);
    reset = 1'b0;
    tick();
    check("rst_ready", int'(rdy16), 1);

    // STEP: one enable cycle, done the cycle after, gray 0->1
    send16(OpStep, 8'd0);
    check("step_en",    int'(en16),   1);
    check("step_busy",  int'(busy16), 1);
    check("step_ready", int'(rdy16),  0);
    check("step_done0", int'(done16), 0);
    tick();
    check("step_done",  int'(done16), 1);
    check("step_en_off", int'(en16),  0);
    check("step_gray",  int'(gray16), 1);
    check("step_idle",  int'(busy16), 0);
    tick();
    check("step_done_pulse", int'(done16), 0);

    // BURST L=5 with two held cycles
    apply_reset();
    send16(OpBurst, 8'd5);
    check("burst_ready", int'(rdy16), 0);
    en_n = 0; done_n = 0; last_en = -1; done_at = -1;
    for (int c = 1; c <= 16; c++) begin
      if (en16) begin en_n++; last_en = c; end
      if (done16) begin done_n++; done_at = c; end
      hold16 = (c == 1 || c == 2);
      tick();
    end
    hold16 = 1'b0;
    check("burst_en_cycles", en_n, 5);
    check("burst_done_cnt",  done_n, 1);
    check("burst_done_time", done_at, last_en + 1);
    check("burst_gray",      int'(gray16), 7);
    check("burst_idle",      int'(busy16), 0);

    // RUN 20 cycles: one wrap at 0x8->0x0, then STEP -> cmd_err, STOP -> idle
    apply_reset();
    send16(OpRun, 8'd0);
    check("run_busy",  int'(busy16), 1);
    check("run_ready", int'(rdy16),  1);
    wraps = 0; pre_wrap = -1; h1 = int'(gray16); h2 = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (wrap16) begin wraps++; pre_wrap = h2; end
      h2 = h1; h1 = int'(gray16);
    end
    check("run_wraps",    wraps, 1);
    check("run_pre_wrap", pre_wrap, 8);
    check("run_gerr",     int'(gerr16), 0);
    send16(OpStep, 8'd0);
    check("run_cmd_err",  int'(err16),  1);
    check("run_no_done",  int'(done16), 0);
    check("run_still",    int'(busy16), 1);
    check("run_en",       int'(en16),   1);
    tick();
    check("run_cmd_err_pulse", int'(err16), 0);
    send16(OpStop, 8'd0);
    check("stop_en",    int'(en16),   0);
    check("stop_busy",  int'(busy16), 0);
    check("stop_done",  int'(done16), 0);
    check("stop_ready", int'(rdy16),  1);

    // Illegal 0x1->0x7 jump sets sticky gray_err
    apply_reset();
    force16 = 1'b1; fval16 = 4'h1;
    tick();
    tick();
    check("force_legal", int'(gerr16), 0);
    fval16 = 4'h7;
    tick();
    check("force_gerr", int'(gerr16), 1);
    force16 = 1'b0;
    send16(OpStep, 8'd0);
    tick();
    send16(OpStep, 8'd0);
    tick();
    check("sticky_gray", int'(gray16), 3);
    check("sticky_gerr", int'(gerr16), 1);

    // BURST L=0: done without enable, never busy
    send16(OpBurst, 8'd0);
    check("b0_done", int'(done16), 1);
    check("b0_en",   int'(en16),   0);
    check("b0_busy", int'(busy16), 0);
    tick();
    check("b0_done_pulse", int'(done16), 0);
    check("b0_en2",   int'(en16),   0);
    check("b0_busy2", int'(busy16), 0);

    // Reset mid BURST L=200
    send16(OpBurst, 8'd200);
    repeat (5) tick();
    check("mid_busy", int'(busy16), 1);
    check("mid_en",   int'(en16),   1);
    reset = 1'b1;
    #1;
    check("mid_rst_en",   int'(en16),   0);
    check("mid_rst_busy", int'(busy16), 0);
    tick();
    reset = 1'b0;
    en_n = 0; done_n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (en16) en_n++;
      if (done16) done_n++;
    end
    check("mid_no_en",   en_n, 0);
    check("mid_no_done", done_n, 0);
    check("mid_ready",   int'(rdy16),  1);
    check("mid_idle",    int'(busy16), 0);

    // SIZE=10 RUN: wrap at 0xD->0x0 without gray_err
    send10(OpRun, 8'd0);
    wraps = 0; pre_wrap = -1; h1 = int'(gray10); h2 = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (wrap10) begin wraps++; pre_wrap = h2; end
      h2 = h1; h1 = int'(gray10);
    end
    check("s10_wraps",    wraps, 1);
    check("s10_pre_wrap", pre_wrap, 13);
    check("s10_gerr",     int'(gerr10), 0);
    send10(OpStop, 8'd0);
    check("s10_stop_en",   int'(en10),   0);
    check("s10_stop_busy", int'(busy10), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
